v_store_sequencer: RTL and testbench
====================================

Name: v_store_sequencer

Overview:
- Upstream issue stage for vector stores in the coprocessor LSU.
- Accepts one store request: opcode, LMUL, base address, stride, and a 512-bit register-group image.
- Walks every element and issues one beat per cycle to the four data-memory banks: four elements per beat, one per bank, with per-bank address and write data.
- Supports mem_ready back-pressure. Pulses done, or err for unsupported opcodes.

Parameters:
- VLEN, 128, vector register length in bits.
- ADDR_W, `DATAMEM_BITS, data-memory word-address width.

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  sequencer idle, can accept a request
- store_op  in  4  v_pkg opcode: VLSU_VSE8/16/32, VLSU_VSSE8/16/32
- lmul  in  3  000=1 reg, 001=2, 010=4, others=1
- base_addr  in  ADDR_W  element-0 word address
- stride  in  5  unsigned element stride in words; strided ops only
- vs_data  in  512  register group, element i at [SEW*i +: SEW]
- mem_ready  in  1  banks accept the current beat
- bank_we  out  4  per-bank write enable
- bank_addr0..3  out  ADDR_W each  bank k address
- bank_wdata0..3  out  32 each  bank k data
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle unsupported-opcode pulse

Behaviour:
Clocking and reset:
- One clock, clk. Reset is synchronous, active-low (nrst).
- Reset values: req_ready=1 (after reset); bank_we=0; all bank_addr=0; all bank_wdata=0; done=0; err=0; FSM in IDLE.
- Reset mid-operation aborts immediately. No further bank_we assertion and no done.

Request capture:
- Accept occurs on a clock edge with req_valid & req_ready.
- On accept, latch store_op, lmul, base_addr, stride and vs_data. Later input changes have no effect.

Element and beat counts:
- SEW comes from store_op: 8, 16 or 32. The vsew CSR is not an input.
- NREG = 1, 2 or 4 from lmul.
- Total elements E = NREG*VLEN/SEW.
- Beats B = E/4. With VLEN=128: e8 gives 4*NREG beats, e16 gives 2*NREG, e32 gives NREG.

FSM states:
- IDLE: req_ready=1, bank_we=0.
  - Accept with a valid opcode goes to ISSUE with beat=0.
  - Accept with an invalid opcode goes to ERR.
- ISSUE: req_ready=0, bank_we=4'b1111. Outputs are registered and depend only on latched state and beat.
  - Beat b, bank k drives element i=4b+k.
  - bank_wdata_k = zero-extend(vs_data[SEW*i +: SEW]) to 32 bits.
  - Unit-stride: bank_addr_k = base_addr + i.
  - Strided: bank_addr_k = base_addr + i*stride.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  - stride=0 is legal: all four banks get the same address.
  - mem_ready=0 holds addr, data and we stable.
  - mem_ready=1 advances the beat. On the last beat (b=B-1), go to DONE.
- DONE: done=1 for one cycle, bank_we=0, then IDLE.
- ERR: err=1 for one cycle, no writes, then IDLE.

Timing and handshake:
- Latency with no stalls: accept at edge t. Beats are visible in cycles t+1 .. t+B. done is high in cycle t+B+1. req_ready returns in cycle t+B+2.
- req_valid while busy is ignored. It is not queued.
- done and a new accept never coincide: req_ready is 0 while done is high.

Test Plan:
- VSE32, lmul=000, base=0x010, vs_data[127:0]=0x44444444_33333333_22222222_11111111, mem_ready=1 -> one beat: addrs 0x010..0x013, wdata 0x11111111, 0x22222222, 0x33333333, 0x44444444; done exactly 2 cycles after accept.
- VSE8, lmul=001, base=0, vs_data bytes 0x00..0x1F -> 8 beats. Beat 7: addrs 28..31, wdata 0x0000001C..0x0000001F. Single done pulse.
- VSSE16, lmul=000, base=0x100, stride=3, halfword i = 0x8000+i -> 2 beats. Beat 1: addrs 0x10C, 0x10F, 0x112, 0x115; wdata 0x00008004..0x00008007 (zero-extended).
- Back-pressure: VSE32 lmul=010 with mem_ready low for 3 cycles during beat 2 -> beat 2 outputs held unchanged. Exactly 4 distinct beats; done at accept+8.
- Wrap and stride 0: base = 2^ADDR_W-2, VSE32 lmul=000 -> addrs 2^ADDR_W-2, 2^ADDR_W-1, 0, 1. VSSE32 with stride=0 -> all four addrs equal base.
- Invalid store_op=4'hF -> err pulse 1 cycle after accept, bank_we never set. nrst low mid-VSE8 lmul=010 -> next cycle bank_we=0, req_ready=1, no done.

Source files
------------

// File: rtl/v_store_sequencer.sv
// ---------------------------------------------------------------------------
// v_store_sequencer
//
// Issue stage for vector stores in the coprocessor LSU. Accepts one store
// request, walks its register-group image and issues one beat per cycle to
// the four data-memory banks. Each beat carries four elements, one per bank.
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   req_valid / req_ready     request handshake (ready only while idle)
//   store_op                  opcode (VSE8/16/32 unit-stride, VSSE8/16/32 strided)
//   lmul                      000=1 reg, 001=2, 010=4, others=1
//   base_addr                 element-0 word address
//   stride                    element stride in words (strided opcodes only)
//   vs_data                   register group, element i at [SEW*i +: SEW]
//   mem_ready                 banks accept the current beat
//   bank_we                   per-bank write enable
//   bank_addr0..3             per-bank word address
//   bank_wdata0..3            per-bank zero-extended element data
//   done                      one-cycle completion pulse
//   err                       one-cycle unsupported-opcode pulse
//
// Opcode encodings (v_pkg): VSE8=0, VSE16=1, VSE32=2, VSSE8=4, VSSE16=5,
// VSSE32=6. Every other value is rejected with an err pulse.
// ---------------------------------------------------------------------------
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif

module v_store_sequencer #(
    parameter int VLEN   = 128,
    parameter int ADDR_W = `DATAMEM_BITS
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        store_op,
    input  logic [2:0]        lmul,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        stride,
    input  logic [511:0]      vs_data,
    input  logic              mem_ready,
    output logic [3:0]        bank_we,
    output logic [ADDR_W-1:0] bank_addr0,
    output logic [ADDR_W-1:0] bank_addr1,
    output logic [ADDR_W-1:0] bank_addr2,
    output logic [ADDR_W-1:0] bank_addr3,
    output logic [31:0]       bank_wdata0,
    output logic [31:0]       bank_wdata1,
    output logic [31:0]       bank_wdata2,
    output logic [31:0]       bank_wdata3,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] VLSU_VSE8   = 4'h0;
    localparam logic [3:0] VLSU_VSE16  = 4'h1;
    localparam logic [3:0] VLSU_VSE32  = 4'h2;
    localparam logic [3:0] VLSU_VSSE8  = 4'h4;
    localparam logic [3:0] VLSU_VSSE16 = 4'h5;
    localparam logic [3:0] VLSU_VSSE32 = 4'h6;

    // e8 with four registers gives the most beats: VLEN/8.
    localparam int BEAT_W = $clog2(VLEN / 8);
    localparam int EIDX_W = BEAT_W + 2;
    localparam int OFF_W  = EIDX_W + 5;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE_S, ERR_S} state_t;

    // Returns {valid, strided, sew[1:0]} where sew 0/1/2 = 8/16/32 bits.
    function automatic logic [3:0] decode(input logic [3:0] op);
        case (op)
            VLSU_VSE8:   return 4'b1000;
            VLSU_VSE16:  return 4'b1001;
            VLSU_VSE32:  return 4'b1010;
            VLSU_VSSE8:  return 4'b1100;
            VLSU_VSSE16: return 4'b1101;
            VLSU_VSSE32: return 4'b1110;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [BEAT_W-1:0] last_beat_of(input logic [1:0] sew,
                                                       input logic [2:0] lm);
        int nreg;
        int beats;
        nreg  = (lm == 3'b001) ? 2 : (lm == 3'b010) ? 4 : 1;
        beats = ((nreg * VLEN) / (8 << sew)) / 4;
        return BEAT_W'(beats - 1);
    endfunction

    // Offsets are computed wide and truncated, so address wrap is silent.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [4:0]        strd,
                                                    input logic              strided,
                                                    input logic [EIDX_W-1:0] i);
        logic [OFF_W-1:0] off;
        off = strided ? OFF_W'(i) * OFF_W'(strd) : OFF_W'(i);
        return base + ADDR_W'(off);
    endfunction

    function automatic logic [31:0] elem_data(input logic [511:0]      d,
                                              input logic [1:0]        sew,
                                              input logic [EIDX_W-1:0] i);
        case (sew)
            2'd0:    return 32'(d[{i, 3'b000} +: 8]);
            2'd1:    return 32'(d[{i[EIDX_W-2:0], 4'b0000} +: 16]);
            default: return d[{i[EIDX_W-3:0], 5'b00000} +: 32];
        endcase
    endfunction

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   last_beat;
    logic [1:0]          sew_q;
    logic                strided_q;
    logic [ADDR_W-1:0]   base_q;
    logic [4:0]          stride_q;
    logic [511:0]        data_q;

    logic [3:0]          dec;
    logic [1:0]          src_sew;
    logic                src_strided;
    logic [ADDR_W-1:0]   src_base;
    logic [4:0]          src_stride;
    logic [511:0]        src_data;
    logic [BEAT_W-1:0]   src_beat;
    logic [ADDR_W-1:0]   nxt_addr  [4];
    logic [31:0]         nxt_wdata [4];

    assign dec = decode(store_op);

    // Next beat image: beat 0 straight from the request while idle,
    // otherwise the following beat from the latched request.
    always_comb begin
        if (state == IDLE) begin
            src_sew     = dec[1:0];
            src_strided = dec[2];
            src_base    = base_addr;
            src_stride  = stride;
            src_data    = vs_data;
            src_beat    = '0;
        end else begin
            src_sew     = sew_q;
            src_strided = strided_q;
            src_base    = base_q;
            src_stride  = stride_q;
            src_data    = data_q;
            src_beat    = beat + 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            nxt_addr[k]  = elem_addr(src_base, src_stride, src_strided, {src_beat, 2'(k)});
            nxt_wdata[k] = elem_data(src_data, src_sew, {src_beat, 2'(k)});
        end
    end

    // Request latch (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            sew_q     <= dec[1:0];
            strided_q <= dec[2];
            base_q    <= base_addr;
            stride_q  <= stride;
            data_q    <= vs_data;
            last_beat <= last_beat_of(dec[1:0], lmul);
        end
    end

    // Control FSM and registered bank outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            beat        <= '0;
            req_ready   <= 1'b1;
            bank_we     <= 4'b0000;
            bank_addr0  <= '0;
            bank_addr1  <= '0;
            bank_addr2  <= '0;
            bank_addr3  <= '0;
            bank_wdata0 <= '0;
            bank_wdata1 <= '0;
            bank_wdata2 <= '0;
            bank_wdata3 <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (dec[3]) begin
                            state       <= ISSUE;
                            beat        <= '0;
                            bank_we     <= 4'b1111;
                            bank_addr0  <= nxt_addr[0];
                            bank_addr1  <= nxt_addr[1];
                            bank_addr2  <= nxt_addr[2];
                            bank_addr3  <= nxt_addr[3];
                            bank_wdata0 <= nxt_wdata[0];
                            bank_wdata1 <= nxt_wdata[1];
                            bank_wdata2 <= nxt_wdata[2];
                            bank_wdata3 <= nxt_wdata[3];
                        end else begin
                            state <= ERR_S;
                            err   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        if (beat == last_beat) begin
                            state   <= DONE_S;
                            bank_we <= 4'b0000;
                            done    <= 1'b1;
                        end else begin
                            beat        <= beat + 1'b1;
                            bank_addr0  <= nxt_addr[0];
                            bank_addr1  <= nxt_addr[1];
                            bank_addr2  <= nxt_addr[2];
                            bank_addr3  <= nxt_addr[3];
                            bank_wdata0 <= nxt_wdata[0];
                            bank_wdata1 <= nxt_wdata[1];
                            bank_wdata2 <= nxt_wdata[2];
                            bank_wdata3 <= nxt_wdata[3];
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_store_sequencer.sv
// ---------------------------------------------------------------------------
// tb_v_store_sequencer
//
// Directed bench for v_store_sequencer: a table of store transactions with
// hand-computed beat contents, plus hand-written sequences for reset state,
// back-pressure, invalid opcode and reset during an operation.
// ---------------------------------------------------------------------------
module tb_v_store_sequencer;

    localparam int AW = 10;

    localparam logic [3:0] OP_VSE8   = 4'h0;
    localparam logic [3:0] OP_VSE16  = 4'h1;
    localparam logic [3:0] OP_VSE32  = 4'h2;
    localparam logic [3:0] OP_VSSE8  = 4'h4;
    localparam logic [3:0] OP_VSSE16 = 4'h5;
    localparam logic [3:0] OP_VSSE32 = 4'h6;

    logic          clk;
    logic          nrst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    store_op;
    logic [2:0]    lmul;
    logic [AW-1:0] base_addr;
    logic [4:0]    stride;
    logic [511:0]  vs_data;
    logic          mem_ready;
    logic [3:0]    bank_we;
    logic [AW-1:0] bank_addr0, bank_addr1, bank_addr2, bank_addr3;
    logic [31:0]   bank_wdata0, bank_wdata1, bank_wdata2, bank_wdata3;
    logic          done;
    logic          err;

    v_store_sequencer #(.VLEN(128), .ADDR_W(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .store_op   (store_op),
        .lmul       (lmul),
        .base_addr  (base_addr),
        .stride     (stride),
        .vs_data    (vs_data),
        .mem_ready  (mem_ready),
        .bank_we    (bank_we),
        .bank_addr0 (bank_addr0),
        .bank_addr1 (bank_addr1),
        .bank_addr2 (bank_addr2),
        .bank_addr3 (bank_addr3),
        .bank_wdata0(bank_wdata0),
        .bank_wdata1(bank_wdata1),
        .bank_wdata2(bank_wdata2),
        .bank_wdata3(bank_wdata3),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][AW-1:0] baddr;
    logic [3:0][31:0]   bwd;
    assign baddr = {bank_addr3, bank_addr2, bank_addr1, bank_addr0};
    assign bwd   = {bank_wdata3, bank_wdata2, bank_wdata1, bank_wdata0};

    typedef struct {
        logic [3:0]         op;
        logic [2:0]         lm;
        logic [AW-1:0]      base;
        logic [4:0]         strd;
        int                 pat;
        int                 beats;
        int                 chk;
        logic [3:0][AW-1:0] addr;
        logic [3:0][31:0]   wd;
    } vec_t;

    int npass;
    int ntotal;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // 0: spec 128-bit word pattern, 1: byte i = i, 2: halfword i = 0x8000+i
    function automatic logic [511:0] pat_data(input int p);
        logic [511:0] d;
        d = '0;
        if (p == 0) begin
            d[127:0] = 128'h44444444_33333333_22222222_11111111;
        end else if (p == 1) begin
            for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        end else begin
            for (int i = 0; i < 32; i++) d[16*i +: 16] = 16'h8000 + 16'(i);
        end
        return d;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] lm,
                                input logic [AW-1:0] base, input logic [4:0] strd,
                                input int pat, input int beats, input int chkb,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.op = op; v.lm = lm; v.base = base; v.strd = strd;
        v.pat = pat; v.beats = beats; v.chk = chkb;
        v.addr = {a3, a2, a1, a0};
        v.wd   = {w3, w2, w1, w0};
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int nb;
        int dc;
        nb = 0;
        dc = 0;
        @(negedge clk);
        store_op  = v.op;
        lmul      = v.lm;
        base_addr = v.base;
        stride    = v.strd;
        vs_data   = pat_data(v.pat);
        mem_ready = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble request inputs; req_valid stays high while busy.
        store_op  = 4'hF;
        lmul      = 3'b111;
        base_addr = ~v.base;
        stride    = ~v.strd;
        vs_data   = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bank_we == 4'b1111) begin
                if (nb == v.chk) begin
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("v%0d_addr%0d", idx, k), 32'(baddr[k]), 32'(v.addr[k]));
                        chk($sformatf("v%0d_wdata%0d", idx, k), bwd[k], v.wd[k]);
                    end
                end
                nb++;
            end
            if (done) begin
                dc = c;
                req_valid = 1'b0;
                break;
            end
        end
        if (dc == 0) begin
            ntotal++;
            req_valid = 1'b0;
            $display("FAIL v%0d_timeout: no done within 40 cycles", idx);
        end
        chk($sformatf("v%0d_beats", idx), 32'(nb), 32'(v.beats));
        chk($sformatf("v%0d_done_cycle", idx), 32'(dc), 32'(v.beats + 1));
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), {31'b0, req_ready}, 32'd1);
        chk($sformatf("v%0d_done_pulse", idx), {31'b0, done}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        npass = 0;
        ntotal = 0;
        nrst = 1'b0;
        req_valid = 1'b0;
        store_op = 4'h0;
        lmul = 3'b000;
        base_addr = '0;
        stride = '0;
        vs_data = '0;
        mem_ready = 1'b1;

        vecs[0] = mk(OP_VSE32, 3'b000, 10'h010, 5'd0, 0, 1, 0,
                     10'h010, 10'h011, 10'h012, 10'h013,
                     32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        vecs[1] = mk(OP_VSE8, 3'b001, 10'h000, 5'd0, 1, 8, 7,
                     10'd28, 10'd29, 10'd30, 10'd31,
                     32'h1C, 32'h1D, 32'h1E, 32'h1F);
        vecs[2] = mk(OP_VSSE16, 3'b000, 10'h100, 5'd3, 2, 2, 1,
                     10'h10C, 10'h10F, 10'h112, 10'h115,
                     32'h8004, 32'h8005, 32'h8006, 32'h8007);
        vecs[3] = mk(OP_VSE32, 3'b000, 10'h3FE, 5'd0, 0, 1, 0,
                     10'h3FE, 10'h3FF, 10'h000, 10'h001,
                     32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        vecs[4] = mk(OP_VSSE32, 3'b000, 10'h055, 5'd0, 0, 1, 0,
                     10'h055, 10'h055, 10'h055, 10'h055,
                     32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        vecs[5] = mk(OP_VSE16, 3'b010, 10'h200, 5'd0, 2, 8, 5,
                     10'h214, 10'h215, 10'h216, 10'h217,
                     32'h8014, 32'h8015, 32'h8016, 32'h8017);
        vecs[6] = mk(OP_VSSE8, 3'b000, 10'h000, 5'd31, 1, 4, 3,
                     10'd372, 10'd403, 10'd434, 10'd465,
                     32'h0C, 32'h0D, 32'h0E, 32'h0F);
        vecs[7] = mk(OP_VSSE32, 3'b010, 10'h3F0, 5'd2, 2, 4, 3,
                     10'h008, 10'h00A, 10'h00C, 10'h00E,
                     32'h80198018, 32'h801B801A, 32'h801D801C, 32'h801F801E);

        // Reset state
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_bank_we", {28'b0, bank_we}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr0", 32'(bank_addr0), 32'd0);
        chk("rst_wdata3", bank_wdata3, 32'd0);

        for (int v = 0; v < 8; v++) run_txn(vecs[v], v);

        // Back-pressure: VSE32 lmul=4, mem_ready low for 3 cycles at beat 2
        begin
            int nb;
            int dc;
            logic [AW-1:0] prev;
            nb = 0;
            dc = 0;
            prev = '0;
            @(negedge clk);
            store_op = OP_VSE32; lmul = 3'b010; base_addr = 10'h020; stride = 5'd0;
            vs_data = pat_data(2); mem_ready = 1'b1; req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (bank_we == 4'b1111) begin
                    if (nb == 0 || bank_addr0 != prev) nb++;
                    prev = bank_addr0;
                end
                if (c >= 3 && c <= 6) begin
                    chk($sformatf("bp_hold_addr0_c%0d", c), 32'(bank_addr0), 32'h028);
                    chk($sformatf("bp_hold_wdata0_c%0d", c), bank_wdata0, 32'h80118010);
                    chk($sformatf("bp_hold_we_c%0d", c), {28'b0, bank_we}, 32'hF);
                end
                if (c == 7) chk("bp_beat3_addr3", 32'(bank_addr3), 32'h02F);
                mem_ready = !(c >= 3 && c <= 5);
                if (done) begin
                    dc = c;
                    break;
                end
            end
            mem_ready = 1'b1;
            chk("bp_distinct_beats", 32'(nb), 32'd4);
            chk("bp_done_cycle", 32'(dc), 32'd8);
        end

        // Invalid opcode
        begin
            logic saw_we;
            @(negedge clk);
            @(negedge clk);
            store_op = 4'hF; lmul = 3'b000; base_addr = 10'h0AA; req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            saw_we = (bank_we != 4'b0000);
            chk("err_pulse", {31'b0, err}, 32'd1);
            chk("err_ready_low", {31'b0, req_ready}, 32'd0);
            chk("err_no_done", {31'b0, done}, 32'd0);
            @(negedge clk);
            saw_we = saw_we | (bank_we != 4'b0000);
            chk("err_one_cycle", {31'b0, err}, 32'd0);
            chk("err_ready_back", {31'b0, req_ready}, 32'd1);
            chk("err_never_we", {31'b0, saw_we}, 32'd0);
        end

        // Reset in the middle of a VSE8 lmul=4 store
        begin
            logic activity;
            activity = 1'b0;
            @(negedge clk);
            store_op = OP_VSE8; lmul = 3'b010; base_addr = 10'h000; vs_data = pat_data(1);
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("midrst_busy_we", {28'b0, bank_we}, 32'hF);
            nrst = 1'b0;
            @(negedge clk);
            chk("midrst_we", {28'b0, bank_we}, 32'd0);
            chk("midrst_ready", {31'b0, req_ready}, 32'd1);
            chk("midrst_done", {31'b0, done}, 32'd0);
            nrst = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done || bank_we != 4'b0000) activity = 1'b1;
            end
            chk("midrst_quiet", {31'b0, activity}, 32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
